// File: rtl/sev_seg_display.sv
// Time-of-day driver for six seven-segment digits: decodes DS1302 packed-BCD
// hour/minute/second bytes into registered active-low segment patterns.

module seg_decoder (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_c
);

    // Active-low segments; bit0 = a ... bit6 = g. Non-BCD nibbles show a dash.
    always_comb begin
        o_seg_c = 7'b0111111;
        case (i_nib)
            4'd0:    o_seg_c = 7'b1000000;
            4'd1:    o_seg_c = 7'b1111001;
            4'd2:    o_seg_c = 7'b0100100;
            4'd3:    o_seg_c = 7'b0110000;
            4'd4:    o_seg_c = 7'b0011001;
            4'd5:    o_seg_c = 7'b0010010;
            4'd6:    o_seg_c = 7'b0000010;
            4'd7:    o_seg_c = 7'b1111000;
            4'd8:    o_seg_c = 7'b0000000;
            4'd9:    o_seg_c = 7'b0010000;
            default: o_seg_c = 7'b0111111;
        endcase
    end

endmodule

module sev_seg_display (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hr,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    output logic [6:0] HEX [0:5]
);

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 7;

    logic [3:0]       w_nib [0:NUM_DIGITS-1];
    logic [SEG_W-1:0] w_seg [0:NUM_DIGITS-1];
    logic             w_unused_bits;

    // Clock-halt, minute bit7 and hour bit6 carry no display information.
    assign w_unused_bits = ^{hr[6], min[7], sec[7]};

    assign w_nib[0] = sec[3:0];
    assign w_nib[1] = {1'b0, sec[6:4]};
    assign w_nib[2] = min[3:0];
    assign w_nib[3] = {1'b0, min[6:4]};
    assign w_nib[4] = hr[3:0];
    // 12-hour mode reuses bit5 as AM/PM, so only bit4 is the tens digit.
    assign w_nib[5] = hr[7] ? {3'b000, hr[4]} : {2'b00, hr[5:4]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg_decoder u_dec (
            .i_nib  (w_nib[g]),
            .o_seg_c(w_seg[g])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                HEX[g] <= {SEG_W{1'b1}};
            end else begin
                HEX[g] <= w_seg[g];
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_display.sv
// Scoreboard bench for sev_seg_display: stimulus pushes expected digit
// patterns, a monitor pops and compares them after every rising edge.
`timescale 1ns/1ps

module tb_sev_seg_display;

    logic       clk;
    logic       rst;
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
    logic [6:0] HEX [0:5];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [41:0] exp_q [$];
    logic        stim_done = 1'b0;

    sev_seg_display dut (
        .clk(clk),
        .rst(rst),
        .hr (hr),
        .min(min),
        .sec(sec),
        .HEX(HEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs, written out from the digit table.
    function automatic logic [6:0] glyph(input int unsigned v);
        logic [6:0] tbl [0:9];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        if (v > 9) return 7'b0111111;
        return tbl[v];
    endfunction

    // Expected {HEX5..HEX0} for one sampled edge.
    function automatic logic [41:0] model(input logic r, input int unsigned h,
                                          input int unsigned m, input int unsigned s);
        int unsigned h_tens;
        if (r) return {42{1'b1}};
        h_tens = (h >= 128) ? (h / 16) % 2 : (h / 16) % 4;
        return {glyph(h_tens), glyph(h % 16),
                glyph((m / 16) % 8), glyph(m % 16),
                glyph((s / 16) % 8), glyph(s % 16)};
    endfunction

    task automatic drive(input logic r, input logic [7:0] h,
                         input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        rst = r; hr = h; min = m; sec = s;
        exp_q.push_back(model(r, int'(h), int'(m), int'(s)));
    endtask

    task automatic compare(input logic [41:0] exp, input string tag);
        for (int i = 0; i < 6; i++) begin
            logic [6:0] e;
            e = exp[i*7 +: 7];
            checks++;
            if (HEX[i] !== e) begin
                failures++;
                $display("FAIL %s HEX%0d got=%b exp=%b", tag, i, HEX[i], e);
            end
        end
    endtask

    // Inputs wiggle between edges; the registered outputs must not follow.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!stim_done) begin
                hr  = 8'($urandom);
                min = 8'($urandom);
                sec = 8'($urandom);
            end
        end
    end

    // Monitor: one expected entry per sampled edge; re-check after the glitch.
    initial begin
        logic [41:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                compare(exp, "edge");
                #3;
                compare(exp, "hold");
            end
        end
    end

    initial begin
        rst = 1'b1; hr = 8'h00; min = 8'h00; sec = 8'h00;

        drive(1'b1, 8'h12, 8'h34, 8'h56);
        drive(1'b1, 8'h12, 8'h34, 8'h56);
        drive(1'b0, 8'h12, 8'h34, 8'h56);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 8'h23, 8'h59, 8'h59);
        drive(1'b0, 8'h05, 8'h88, 8'hB7);
        drive(1'b0, 8'hB1, 8'h00, 8'h0A);
        drive(1'b0, 8'h92, 8'hFF, 8'hFF);
        drive(1'b0, 8'h3C, 8'h7E, 8'h75);
        drive(1'b1, 8'h11, 8'h22, 8'h33);
        drive(1'b0, 8'h11, 8'h22, 8'h33);

        for (int n = 0; n < 300; n++) begin
            drive(($urandom % 16) == 0, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        @(negedge clk);
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #6;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
